// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - clocked return-address stack with JAL/JALR link hint decode
// Optional statistics counters enabled by defining RAS_STATS_EN.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   valid_in,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        imm_in,
    input  logic [XLEN-1:0]        rs1_val,
    input  logic                   ckpt_in,
    input  logic                   flush_in,
    output logic                   pred_valid_out,
    output logic [XLEN-1:0]        pc_jmp_out,
    output logic                   pushras,
    output logic                   popras,
    output logic                   empty_out,
    output logic                   full_out,
    output logic                   overflow_out,
    output logic                   underflow_out,
`ifdef RAS_STATS_EN
    output logic [CNT_W-1:0]       push_cnt,
    output logic [CNT_W-1:0]       pop_cnt,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic [CNT_W-1:0]       unf_cnt,
`endif
    output logic [$clog2(DEPTH):0] depth_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    if (CNT_W < 1 || DEPTH < 2) begin : g_bad_params
    end

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   tos_q, tos_d, snap_tos_q, snap_tos_d, tos_m1;
    logic [CW-1:0]   count_q, count_d, snap_cnt_q, snap_cnt_d;
    logic [XLEN-1:0] pc_q, pc_d, link_addr, jalr_tgt, top_val;
    logic            pred_q, pred_d, push_q, push_d, pop_q, pop_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            mem_we;
    logic [PW-1:0]   mem_wa;
    logic            rd_link, rs_link, is_full, is_empty;

    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs_link   = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign tos_m1    = tos_q - PW'(1);
    assign link_addr = pc_in + XLEN'(4);
    assign jalr_tgt  = (rs1_val + imm_in) & ~XLEN'(1);
    assign top_val   = mem[tos_m1];
    assign is_full   = (count_q == CW'(DEPTH));
    assign is_empty  = (count_q == '0);

    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        snap_tos_d = snap_tos_q;
        snap_cnt_d = snap_cnt_q;
        pc_d       = pc_q;
        pred_d     = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = tos_q;
        if (flush_in) begin
            tos_d   = snap_tos_q;
            count_d = snap_cnt_q;
        end else begin
            if (ckpt_in) begin
                snap_tos_d = tos_q;
                snap_cnt_d = count_q;
            end
            if (valid_in) begin
                pred_d = 1'b1;
                if (opcode == OP_JAL) begin
                    pc_d = pc_in + imm_in;
                    if (rd_link) begin
                        push_d = 1'b1;
                        mem_we = 1'b1;
                        tos_d  = tos_q + PW'(1);
                        if (is_full) ovf_d = 1'b1;
                        else         count_d = count_q + CW'(1);
                    end
                end else if (opcode == OP_JALR) begin
                    pc_d = jalr_tgt;
                    if (rs_link && !(rd_link && rd == rs1)) begin
                        // pop or pop+push: the return comes from the stack top when present
                        if (is_empty) begin
                            unf_d = 1'b1;
                        end else begin
                            pc_d  = top_val;
                            pop_d = 1'b1;
                        end
                    end
                    if (rd_link && rs_link && rd != rs1 && !is_empty) begin
                        push_d = 1'b1;
                        mem_we = 1'b1;
                        mem_wa = tos_m1;
                    end else if (rd_link) begin
                        push_d = 1'b1;
                        mem_we = 1'b1;
                        tos_d  = tos_q + PW'(1);
                        if (is_full) ovf_d = 1'b1;
                        else         count_d = count_q + CW'(1);
                    end else if (pop_d) begin
                        tos_d   = tos_m1;
                        count_d = count_q - CW'(1);
                    end
                end else begin
                    pc_d = link_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            tos_q      <= '0;
            count_q    <= '0;
            snap_tos_q <= '0;
            snap_cnt_q <= '0;
            pc_q       <= '0;
            pred_q     <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            snap_tos_q <= snap_tos_d;
            snap_cnt_q <= snap_cnt_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset_in) mem[mem_wa] <= link_addr;
    end

`ifdef RAS_STATS_EN
    logic [CNT_W-1:0] push_cnt_q, pop_cnt_q, ovf_cnt_q, unf_cnt_q;
    always_ff @(posedge clk) begin
        if (reset_in) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            unf_cnt_q  <= '0;
        end else begin
            if (push_d && push_cnt_q != '1) push_cnt_q <= push_cnt_q + CNT_W'(1);
            if (pop_d  && pop_cnt_q  != '1) pop_cnt_q  <= pop_cnt_q  + CNT_W'(1);
            if (ovf_d  && ovf_cnt_q  != '1) ovf_cnt_q  <= ovf_cnt_q  + CNT_W'(1);
            if (unf_d  && unf_cnt_q  != '1) unf_cnt_q  <= unf_cnt_q  + CNT_W'(1);
        end
    end
    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;
    assign unf_cnt  = unf_cnt_q;
`endif

    assign pred_valid_out = pred_q;
    assign pc_jmp_out     = pc_q;
    assign pushras        = push_q;
    assign popras         = pop_q;
    assign overflow_out   = ovf_q;
    assign underflow_out  = unf_q;
    assign empty_out      = is_empty;
    assign full_out       = is_full;
    assign depth_out      = count_q;
endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - randomized and directed bench for ras_stack against a stack model
module tb_ras_stack;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ADD  = 7'b0110011;

    logic clk = 1'b0;
    logic reset_in, valid_in, ckpt_in, flush_in;
    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic [XLEN-1:0] pc_in, imm_in, rs1_val;
    logic pred_valid_out, pushras, popras, empty_out, full_out, overflow_out, underflow_out;
    logic [XLEN-1:0] pc_jmp_out;
    logic [$clog2(DEPTH):0] depth_out;
`ifdef RAS_STATS_EN
    logic [CNT_W-1:0] push_cnt, pop_cnt, ovf_cnt, unf_cnt;
    int m_pushc, m_popc, m_ovfc, m_unfc;
`endif

    ras_stack #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_in(reset_in), .valid_in(valid_in), .opcode(opcode),
        .rd(rd), .rs1(rs1), .pc_in(pc_in), .imm_in(imm_in), .rs1_val(rs1_val),
        .ckpt_in(ckpt_in), .flush_in(flush_in), .pred_valid_out(pred_valid_out),
        .pc_jmp_out(pc_jmp_out), .pushras(pushras), .popras(popras),
        .empty_out(empty_out), .full_out(full_out), .overflow_out(overflow_out),
        .underflow_out(underflow_out),
`ifdef RAS_STATS_EN
        .push_cnt(push_cnt), .pop_cnt(pop_cnt), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt),
`endif
        .depth_out(depth_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [XLEN-1:0] m_mem [DEPTH];
    int m_tos, m_cnt, s_tos, s_cnt;
    logic [XLEN-1:0] m_pc;

    task automatic step(input logic rst, input logic v, input logic [6:0] op,
                        input logic [4:0] rdi, input logic [4:0] rsi,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input logic [XLEN-1:0] rsv, input logic ck, input logic fl);
        bit e_pv = 0, e_push = 0, e_pop = 0, e_ovf = 0, e_unf = 0;
        bit rdl, rsl;
        int kind;
        logic [XLEN-1:0] tgt;
        reset_in = rst; valid_in = v; opcode = op; rd = rdi; rs1 = rsi;
        pc_in = pc; imm_in = imm; rs1_val = rsv; ckpt_in = ck; flush_in = fl;
        if (rst) begin
            m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0; m_pc = '0;
`ifdef RAS_STATS_EN
            m_pushc = 0; m_popc = 0; m_ovfc = 0; m_unfc = 0;
`endif
        end else if (fl) begin
            m_tos = s_tos; m_cnt = s_cnt;
        end else begin
            if (ck) begin s_tos = m_tos; s_cnt = m_cnt; end
            if (v) begin
                rdl = (rdi == 1 || rdi == 5);
                rsl = (rsi == 1 || rsi == 5);
                kind = 0;
                if (op == JAL) begin
                    kind = rdl ? 1 : 0;
                    tgt = pc + imm;
                end else if (op == JALR) begin
                    if (!rdl && !rsl) kind = 0;
                    else if (!rdl)    kind = 2;
                    else if (!rsl)    kind = 1;
                    else if (rdi != rsi) kind = 3;
                    else kind = 1;
                    tgt = (rsv + imm) & ~32'd1;
                    if (kind >= 2 && m_cnt > 0) tgt = m_mem[(m_tos + DEPTH - 1) % DEPTH];
                end else begin
                    tgt = pc + 4;
                end
                e_pv = 1;
                m_pc = tgt;
                if (kind == 3 && m_cnt > 0) begin
                    m_mem[(m_tos + DEPTH - 1) % DEPTH] = pc + 4;
                    e_pop = 1; e_push = 1;
                end else begin
                    if (kind == 2 || kind == 3) begin
                        if (m_cnt > 0) begin
                            m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--; e_pop = 1;
                        end else e_unf = 1;
                    end
                    if (kind == 1 || kind == 3) begin
                        m_mem[m_tos] = pc + 4;
                        m_tos = (m_tos + 1) % DEPTH;
                        if (m_cnt == DEPTH) e_ovf = 1; else m_cnt++;
                        e_push = 1;
                    end
                end
`ifdef RAS_STATS_EN
                if (e_push && m_pushc < 65535) m_pushc++;
                if (e_pop  && m_popc  < 65535) m_popc++;
                if (e_ovf  && m_ovfc  < 65535) m_ovfc++;
                if (e_unf  && m_unfc  < 65535) m_unfc++;
`endif
            end
        end
        @(posedge clk);
        #1;
        check_eq("pred_valid", pred_valid_out, e_pv);
        check_eq("pc_jmp", pc_jmp_out, m_pc);
        check_eq("pushras", pushras, e_push);
        check_eq("popras", popras, e_pop);
        check_eq("overflow", overflow_out, e_ovf);
        check_eq("underflow", underflow_out, e_unf);
        check_eq("depth", depth_out, m_cnt);
        check_eq("empty", empty_out, m_cnt == 0);
        check_eq("full", full_out, m_cnt == DEPTH);
`ifdef RAS_STATS_EN
        check_eq("push_cnt", push_cnt, m_pushc);
        check_eq("pop_cnt", pop_cnt, m_popc);
        check_eq("ovf_cnt", ovf_cnt, m_ovfc);
        check_eq("unf_cnt", unf_cnt, m_unfc);
`endif
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0; m_pc = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        step(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_empty", empty_out, 1'b1);

        step(0, 1, JAL, 1, 0, 32'h100, 32'h40, 0, 0, 0);
        check_eq("tp_jal_pc", pc_jmp_out, 32'h140);
        step(0, 1, JALR, 0, 1, 32'h140, 0, 32'h999, 0, 0);
        check_eq("tp_ret_pc", pc_jmp_out, 32'h104);

        for (int i = 0; i < 5; i++) step(0, 1, JAL, 1, 0, 32'(i * 16), 0, 0, 0, 0);
        check_eq("tp_ovf", overflow_out, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, JALR, 0, 5, 0, 0, 32'h777, 0, 0);
            check_eq("tp_pop_val", pc_jmp_out, 32'h44 - 32'(i * 16));
        end
        step(0, 1, JALR, 0, 1, 0, 32'h10, 32'h2001, 0, 0);
        check_eq("tp_unf_pc", pc_jmp_out, 32'h2010);

        step(0, 1, JAL, 1, 0, 32'h200, 32'h8, 0, 0, 0);
        step(0, 1, JALR, 5, 1, 32'h300, 0, 32'h55, 0, 0);
        check_eq("tp_pp_pc", pc_jmp_out, 32'h204);
        step(0, 1, JALR, 0, 1, 32'h400, 0, 32'h55, 0, 0);
        check_eq("tp_pp_top", pc_jmp_out, 32'h304);

        step(0, 1, JALR, 1, 1, 32'h10, 0, 32'h1001, 0, 0);
        check_eq("tp_same_link", pc_jmp_out, 32'h1000);
        step(0, 1, JAL, 0, 0, 32'h500, 32'h20, 0, 0, 0);
        step(0, 1, ADD, 1, 1, 32'h600, 32'h20, 0, 0, 0);
        check_eq("tp_add_pc", pc_jmp_out, 32'h604);
        step(0, 0, ADD, 0, 0, 32'h700, 0, 0, 0, 0);

        step(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, JAL, 1, 0, 32'h10, 0, 0, 0, 0);
        step(0, 1, JAL, 1, 0, 32'h20, 0, 0, 0, 0);
        step(0, 0, ADD, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, JAL, 1, 0, 32'h30, 0, 0, 0, 0);
        step(0, 1, JAL, 1, 0, 32'h40, 0, 0, 0, 0);
        step(0, 1, JAL, 1, 0, 32'h50, 0, 0, 0, 1);
        check_eq("tp_flush_depth", depth_out, 2);
        step(0, 1, JAL, 1, 0, 32'h60, 0, 0, 0, 0);
        step(1, 1, JAL, 1, 0, 32'h70, 0, 0, 0, 0);
        check_eq("tp_rst_push", pushras, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 3))
                0: op = JAL;
                1, 2: op = JALR;
                default: op = ($urandom_range(0, 1) != 0) ? ADD : 7'($urandom);
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, op,
                 pick_reg(), pick_reg(), $urandom & ~32'd3, $urandom,
                 $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Parametrised, clocked return-address stack with built-in RISC-V link-register hint decode. Successor to the combinational RAS controller.
- Holds DEPTH return addresses in a circular buffer and classifies JAL/JALR as push, pop, pop+push or none.
- Produces a registered predicted next PC, and supports checkpoint/restore of the stack pointer for front-end flushes.
- Sits between the decoder and the PC mux.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 8, number of stack entries; power of 2, ≥2.
- CNT_W, 16, width of the statistics counters (used only with RAS_STATS_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset_in  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction fields are valid this cycle.
- opcode  in  7  instruction opcode.
- rd  in  5  destination register index.
- rs1  in  5  source register index.
- pc_in  in  XLEN  PC of the instruction.
- imm_in  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  rs1 operand value, used for JALR fallback.
- ckpt_in  in  1  save {tos,count} snapshot.
- flush_in  in  1  restore snapshot.
- pred_valid_out  out  1  pc_jmp_out valid, 1-cycle pulse.
- pc_jmp_out  out  XLEN  predicted next PC.
- pushras  out  1  push performed, pulse.
- popras  out  1  pop performed, pulse.
- empty_out  out  1  count==0.
- full_out  out  1  count==DEPTH.
- overflow_out  out  1  oldest entry overwritten, pulse.
- underflow_out  out  1  pop attempted while empty, pulse.
- depth_out  out  $clog2(DEPTH)+1  current count.

Behaviour:
- Classification (link register = x1 or x5):
  - rdL = rd is a link register; rsL = rs1 is a link register.
  - JAL (1101111): rdL → push; otherwise none.
  - JALR (1100111): !rdL & !rsL → none; !rdL & rsL → pop; rdL & !rsL → push; rdL & rsL & rd≠rs1 → pop+push; rdL & rsL & rd==rs1 → push.
  - Any other opcode → none.
- Targets:
  - JAL: pc_in+imm_in.
  - JALR none/push: (rs1_val+imm_in) & ~1.
  - pop and pop+push: mem[tos-1]; if the stack is empty, fall back to the JALR target.
  - Non-jump: pc_in+4.
  - All arithmetic is modulo 2^XLEN.
- Latency: inputs are sampled when valid_in=1. At the next rising edge, all outputs and the stack update together. Pulse outputs are high for exactly one cycle. With valid_in=0, pred_valid_out, pushras, popras, overflow_out and underflow_out are 0, and pc_jmp_out holds its value.
- Storage: mem[DEPTH] of XLEN bits; tos is the next-write index, modulo DEPTH; count ranges 0..DEPTH.
- Push: mem[tos]←pc_in+4; tos←tos+1. If count==DEPTH, count stays and overflow_out=1 (oldest entry lost); otherwise count+1.
- Pop:
  - count>0: read mem[tos-1]; tos←tos-1; count-1.
  - count==0: underflow_out=1, popras=0, tos and count unchanged.
- Pop+push:
  - count>0: the read uses the old mem[tos-1], and the same slot is then overwritten with pc_in+4. tos and count unchanged; popras=pushras=1.
  - count==0: underflow_out=1, then a normal push (count→1); pushras=1, popras=0.
- Checkpoint: ckpt_in=1 stores {tos,count} into the snapshot at the edge. ckpt_in and valid_in in the same cycle: the snapshot captures the pre-operation values.
- Flush: flush_in=1 restores {tos,count} from the snapshot. In that cycle valid_in is ignored and all pulse outputs are 0. Entry contents are not restored.
- Priority: reset_in > flush_in > ckpt_in / valid_in.
- Reset: tos=0, count=0, snapshot=0, pc_jmp_out=0, all pulses 0, empty_out=1, full_out=0, depth_out=0. mem is not cleared. Reset mid-operation discards the in-flight operation.

Optional Feature:
- RAS_STATS_EN defined: adds outputs push_cnt, pop_cnt, ovf_cnt, unf_cnt (CNT_W each).
  - Counters increment on the pushras, popras, overflow_out and underflow_out events respectively.
  - Counters saturate at all-ones.
  - Counters clear on reset_in only, not on flush.
- RAS_STATS_EN undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- DEPTH=4. JAL rd=x1 at pc 0x100, imm 0x40 → next cycle pc_jmp_out=0x140, pushras=1, depth_out=1. Then JALR rd=x0 rs1=x1 → pc_jmp_out=0x104, popras=1, empty_out=1.
- Five JAL rd=x1 at pc 0x0,0x10,0x20,0x30,0x40 → fifth cycle: overflow_out=1, full_out=1. Four pops then return 0x44,0x34,0x24,0x14; a fifth pop gives underflow_out=1 and pc_jmp_out=(rs1_val+imm)&~1.
- With stack top 0x204: JALR rd=x5 rs1=x1 at pc 0x300 → pc_jmp_out=0x204, popras=pushras=1, depth unchanged, new top 0x304.
- Same-cycle checks:
  - JALR rd=x1 rs1=x1, rs1_val=0x1001, imm=0 → push, pc_jmp_out=0x1000.
  - JAL rd=x0 → none, pc_jmp_out=pc+imm.
  - add opcode → pc+4, pred_valid_out=1, no pushras/popras pulses.
- ckpt_in at depth 2, then 2 pushes, then flush_in together with valid_in JAL rd=x1 → depth_out=2, no pushras.
- Reset asserted during a push cycle → depth_out=0, pushras=0. With RAS_STATS_EN, all counters read 0.
